// File: rtl/uart_rx_os.sv
// -----------------------------------------------------------------------------
// uart_rx_os -- oversampled UART receiver
//
// Deserializes asynchronous 8N1 frames (8E1 when UART_RX_PARITY_EN is defined)
// from the rx line into parallel bytes for the protocol mux. Each bit is
// CLKS_PER_BIT clocks long. The start bit is qualified at its midpoint, and
// every later bit is sampled one full bit period after the previous sample.
// All samples therefore land at mid-bit.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per bit period (even, >= 4)
//   DATA_BITS     data bits per frame, LSB first (5..8)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   rx_enable   receiver enable; low forces IDLE and drops any partial frame
//   rx_in       asynchronous serial line, idle high
//   rx_data     last correctly received word (held across errors/aborts)
//   valid       one-cycle pulse: rx_data was just updated
//   busy        high whenever the receiver is not in IDLE
//   frame_err   one-cycle pulse: stop bit sampled low
//   parity_err  (UART_RX_PARITY_EN only) one-cycle pulse alongside valid when
//               the even-parity check fails
//
// Configuration macro: UART_RX_PARITY_EN
//   Defined   -> PARITY state between DATA and STOP, parity_err port present.
//   Undefined -> plain 8N1, no parity state or port.
//
// Timing: valid rises CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 3 cycles
// after rx_in falls. The 3 cycles are two synchronizer stages plus the output
// register. The parity build adds one more bit period.
// -----------------------------------------------------------------------------
module uart_rx_os #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_enable,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 valid,
  output logic                 busy,
  output logic                 frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  // Sample points within a bit period.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [IDX_W-1:0]       bit_idx;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   rx_meta;
  logic                   rx_s;
`ifdef UART_RX_PARITY_EN
  logic                   parity_bit;
`endif

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer. Every decision below uses rx_s only.
  // ---------------------------------------------------------------------------
  // NOTE: the synchronizer resets to 1 (line idle), not 0. A zero here would
  // look like a start bit on the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM with registered outputs.
  //   IDLE  -> START  on a low line
  //   START -> DATA   if still low at half a bit, else back to IDLE (glitch)
  //   DATA  -> STOP   (or PARITY) after DATA_BITS full-period samples
  //   STOP  -> IDLE   good stop bit: publish the word
  //   STOP  -> BREAK  low stop bit: flag it, then wait for the line to recover
  //   BREAK -> IDLE   once the line is high again
  // ---------------------------------------------------------------------------
  // NOTE: all state and outputs here use non-blocking assignments. The pulse
  // outputs are cleared at the top of every cycle and set only in the branch
  // that fires, so each pulse lasts exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      rx_data    <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (!rx_enable) begin
        // Disabling discards any partial frame silently. rx_data is kept.
        state   <= IDLE;
        bit_cnt <= '0;
        bit_idx <= '0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state   <= START;
              bit_cnt <= '0;
              busy    <= 1'b1;
            end
          end

          START: begin
            if (bit_cnt == HALF_LAST) begin
              bit_cnt <= '0;
              if (!rx_s) begin
                state   <= DATA;
                bit_idx <= '0;
              end else begin
                // Line went back high before mid-start: treat as noise.
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end

          DATA: begin
            if (bit_cnt == FULL_LAST) begin
              bit_cnt <= '0;
              // LSB arrives first; shifting right leaves it in bit 0 at the end.
              shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
              if (bit_idx == IDX_LAST) begin
                bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                state   <= PARITY;
`else
                state   <= STOP;
`endif
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end

`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (bit_cnt == FULL_LAST) begin
              bit_cnt    <= '0;
              parity_bit <= rx_s;
              state      <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
`endif

          STOP: begin
            if (bit_cnt == FULL_LAST) begin
              bit_cnt <= '0;
              if (rx_s) begin
                rx_data <= shift_reg;
                valid   <= 1'b1;
`ifdef UART_RX_PARITY_EN
                // Even parity: the data bits and the parity bit together hold
                // an even number of ones.
                parity_err <= (^shift_reg) ^ parity_bit;
`endif
                state   <= IDLE;
                busy    <= 1'b0;
              end else begin
                frame_err <= 1'b1;
                state     <= BREAK;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end

          BREAK: begin
            // Ignore the line until it returns high. A held-low break must
            // not be read as a stream of start bits.
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end

          default: begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
